response_packetizer: RTL and testbench

Egress counterpart of the ingress header parser: turns completion descriptors from the compute slots into AXI-Stream response packets for the network side. Each packet is a two-beat header followed by a counted payload forwarded from the compute unit. Once the final beat of a packet is accepted downstream, the block returns the slot to the slot allocator's free port.

---
 rtl/response_packetizer_if.sv | 42 ++++
 rtl/response_packetizer.sv | 190 +++++++++++++++++++
 tb/tb_response_packetizer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/response_packetizer_if.sv
// Handshake bundle for response_packetizer: completion descriptors, payload in, response stream out.
interface response_packetizer_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned FUNC_ID_WIDTH = 16,
    parameter int unsigned TOKEN_WIDTH   = 64,
    parameter int unsigned SLOT_ID_WIDTH = 4
);
    logic                     cmp_valid;
    logic                     cmp_ready;
    logic [SLOT_ID_WIDTH-1:0] cmp_slot;
    logic [FUNC_ID_WIDTH-1:0] cmp_func_id;
    logic [TOKEN_WIDTH-1:0]   cmp_token;
    logic [7:0]               cmp_status;
    logic [7:0]               cmp_len;

    logic [DATA_WIDTH-1:0]    s_pl_tdata;
    logic                     s_pl_tvalid;
    logic                     s_pl_tready;

    logic [DATA_WIDTH-1:0]    m_axis_tdata;
    logic                     m_axis_tlast;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;

    modport master (
        output cmp_valid, cmp_slot, cmp_func_id, cmp_token, cmp_status, cmp_len,
        input  cmp_ready,
        output s_pl_tdata, s_pl_tvalid,
        input  s_pl_tready,
        input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  cmp_valid, cmp_slot, cmp_func_id, cmp_token, cmp_status, cmp_len,
        output cmp_ready,
        input  s_pl_tdata, s_pl_tvalid,
        output s_pl_tready,
        output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );
endinterface

// File: rtl/response_packetizer.sv
// Turns completion descriptors into AXI-Stream response packets (2 header beats + forwarded payload)
// and releases the slot to the allocator once the final beat is accepted.
module response_packetizer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned FUNC_ID_WIDTH = 16,
    parameter int unsigned TOKEN_WIDTH   = 64,
    parameter int unsigned SLOT_ID_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    response_packetizer_if.slave     bus,
    output logic [SLOT_ID_WIDTH-1:0] free_slot_id,
    output logic                     free_en,
    output logic [31:0]              cnt_packets,
    output logic [31:0]              cnt_stalls
);

    localparam int unsigned DESC_W = SLOT_ID_WIDTH + FUNC_ID_WIDTH + TOKEN_WIDTH + 16;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR0    = 2'd1;
    localparam logic [1:0] S_HDR1    = 2'd2;
    localparam logic [1:0] S_PAYLOAD = 2'd3;

    localparam logic [15:0] HDR_MAGIC = 16'hD15C;

    logic [1:0]               state_q;
    logic [1:0]               state_d;

    logic [DESC_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         fifo_cnt_q;
    logic                     fifo_full_c;
    logic                     fifo_empty_c;
    logic                     push_c;
    logic                     pop_c;

    logic [SLOT_ID_WIDTH-1:0] head_slot;
    logic [FUNC_ID_WIDTH-1:0] head_func;
    logic [TOKEN_WIDTH-1:0]   head_token;
    logic [7:0]               head_status;
    logic [7:0]               head_len;

    logic [SLOT_ID_WIDTH-1:0] slot_q;
    logic [TOKEN_WIDTH-1:0]   token_q;
    logic [7:0]               len_q;
    logic [7:0]               beat_cnt_q;

    logic [DATA_WIDTH-1:0]    hdr_tdata_q;
    logic                     hdr_tvalid_q;
    logic                     hdr_tlast_q;

    logic                     beat_hs_c;
    logic                     pl_last_c;
    logic                     done_c;

    // Descriptor FIFO status; a full FIFO refuses a push even when popping the same cycle
    assign fifo_full_c  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_c = (fifo_cnt_q == '0);
    assign bus.cmp_ready = !rst && !fifo_full_c;
    assign push_c       = bus.cmp_valid && bus.cmp_ready;

    assign {head_slot, head_func, head_token, head_status, head_len} = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= {bus.cmp_slot, bus.cmp_func_id, bus.cmp_token,
                                   bus.cmp_status, bus.cmp_len};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Header beats come from registers; payload beats are a straight pass-through
    assign pl_last_c = (beat_cnt_q == (len_q - 8'd1));

    always_comb begin
        bus.m_axis_tdata  = hdr_tdata_q;
        bus.m_axis_tvalid = hdr_tvalid_q;
        bus.m_axis_tlast  = hdr_tlast_q;
        bus.s_pl_tready   = 1'b0;
        if (state_q == S_PAYLOAD) begin
            bus.m_axis_tdata  = bus.s_pl_tdata;
            bus.m_axis_tvalid = bus.s_pl_tvalid;
            bus.m_axis_tlast  = pl_last_c;
            bus.s_pl_tready   = bus.m_axis_tready;
        end
    end

    assign beat_hs_c = bus.m_axis_tvalid && bus.m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state; a completing packet chains straight into the next header when one is queued
    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_c) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (beat_hs_c) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (beat_hs_c) begin
                    if (len_q == 8'd0) begin
                        done_c  = 1'b1;
                        state_d = fifo_empty_c ? S_IDLE : S_HDR0;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat_hs_c && pl_last_c) begin
                    done_c  = 1'b1;
                    state_d = fifo_empty_c ? S_IDLE : S_HDR0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pop_c = !fifo_empty_c && ((state_q == S_IDLE) || done_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            token_q      <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            hdr_tdata_q  <= '0;
            hdr_tvalid_q <= 1'b0;
            hdr_tlast_q  <= 1'b0;
        end else if (pop_c) begin
            slot_q       <= head_slot;
            token_q      <= head_token;
            len_q        <= head_len;
            beat_cnt_q   <= '0;
            hdr_tdata_q  <= DATA_WIDTH'({HDR_MAGIC, head_status, 8'(head_slot), 32'(head_func)});
            hdr_tvalid_q <= 1'b1;
            hdr_tlast_q  <= 1'b0;
        end else if ((state_q == S_HDR0) && beat_hs_c) begin
            hdr_tdata_q  <= DATA_WIDTH'(token_q);
            hdr_tlast_q  <= (len_q == 8'd0);
        end else if ((state_q == S_HDR1) && beat_hs_c) begin
            hdr_tvalid_q <= 1'b0;
            hdr_tlast_q  <= 1'b0;
        end else if ((state_q == S_PAYLOAD) && beat_hs_c) begin
            beat_cnt_q   <= beat_cnt_q + 8'd1;
        end
    end

    // Slot release pulse and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            free_en      <= 1'b0;
            free_slot_id <= '0;
            cnt_packets  <= '0;
            cnt_stalls   <= '0;
        end else begin
            free_en      <= done_c;
            free_slot_id <= done_c ? slot_q : '0;
            if (done_c) cnt_packets <= cnt_packets + 32'd1;
            if (bus.m_axis_tvalid && !bus.m_axis_tready) cnt_stalls <= cnt_stalls + 32'd1;
        end
    end

endmodule

// File: tb/tb_response_packetizer.sv
// Self-checking bench for response_packetizer: descriptor table plus scoreboarded output beats.
module tb_response_packetizer;

    logic        clk;
    logic        rst;
    logic        free_en;
    logic [3:0]  free_slot_id;
    logic [31:0] cnt_packets;
    logic [31:0] cnt_stalls;

    response_packetizer_if bus ();

    response_packetizer dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .free_slot_id (free_slot_id),
        .free_en      (free_en),
        .cnt_packets  (cnt_packets),
        .cnt_stalls   (cnt_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0]  slot;
        logic [15:0] func;
        logic [63:0] token;
        logic [7:0]  status;
        logic [7:0]  len;
        bit          toggle;
        logic [63:0] pl_base;
        logic [63:0] exp_beat0;
    } vec_t;

    beat_t       exp_q  [$];
    logic [3:0]  free_q [$];
    logic [63:0] pl_q   [$];

    int checks      = 0;
    int errors      = 0;
    int mdl_pkts    = 0;
    int mdl_stalls  = 0;
    int free_pulses = 0;
    bit pl_hold     = 1'b0;
    bit pl_toggle   = 1'b0;
    bit pl_hs_seen  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat0(input logic [3:0] slot, input logic [15:0] func,
                                          input logic [7:0] status);
        return {16'hD15C, status, 4'h0, slot, 16'h0000, func};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmp_ready"},    64'(bus.cmp_ready),     64'd0);
        check({tag, "_tvalid"},       64'(bus.m_axis_tvalid), 64'd0);
        check({tag, "_tlast"},        64'(bus.m_axis_tlast),  64'd0);
        check({tag, "_tdata"},        bus.m_axis_tdata,       64'd0);
        check({tag, "_s_pl_tready"},  64'(bus.s_pl_tready),   64'd0);
        check({tag, "_free_en"},      64'(free_en),           64'd0);
        check({tag, "_free_slot_id"}, 64'(free_slot_id),      64'd0);
        check({tag, "_cnt_packets"},  64'(cnt_packets),       64'd0);
        check({tag, "_cnt_stalls"},   64'(cnt_stalls),        64'd0);
    endtask

    // Drive one descriptor; expectations are queued only if the DUT accepts it
    task automatic push_desc(input logic [3:0] slot, input logic [15:0] func, input logic [63:0] token,
                             input logic [7:0] status, input logic [7:0] len, input logic [63:0] exp_b0,
                             input logic [63:0] pl_base, input int max_wait, output bit accepted);
        beat_t b;
        accepted        = 1'b0;
        bus.cmp_valid   = 1'b1;
        bus.cmp_slot    = slot;
        bus.cmp_func_id = func;
        bus.cmp_token   = token;
        bus.cmp_status  = status;
        bus.cmp_len     = len;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (bus.cmp_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                b.data = exp_b0; b.last = 1'b0;         exp_q.push_back(b);
                b.data = token;  b.last = (len == 8'd0); exp_q.push_back(b);
                for (int k = 0; k < int'(len); k++) begin
                    pl_q.push_back(pl_base + 64'(k + 1));
                    b.data = pl_base + 64'(k + 1);
                    b.last = (k == int'(len) - 1);
                    exp_q.push_back(b);
                end
                free_q.push_back(slot);
                break;
            end
            @(posedge clk);
        end
        #1;
        bus.cmp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && free_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout beats_left=%0d frees_left=%0d required=0", tag,
                     exp_q.size(), free_q.size());
        end
        step();
    endtask

    // Output monitor: scoreboard compare, stall model, free-pulse check
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%h required=none", bus.m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", bus.m_axis_tdata, e.data);
                        check("beat_last", 64'(bus.m_axis_tlast), 64'(e.last));
                        if (e.last) mdl_pkts++;
                    end
                end
                if (bus.m_axis_tvalid && !bus.m_axis_tready) mdl_stalls++;
                if (bus.s_pl_tvalid && bus.s_pl_tready) pl_hs_seen = 1'b1;
                if (free_en) begin
                    free_pulses++;
                    if (free_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_free_en slot=%0d required=none", free_slot_id);
                    end else begin
                        check("free_slot", 64'(free_slot_id), 64'(free_q.pop_front()));
                    end
                end
            end
        end
    end

    // Payload source: presents pl_q head, optionally valid only every other cycle
    initial begin : pl_driver
        bit phase;
        phase           = 1'b0;
        bus.s_pl_tvalid = 1'b0;
        bus.s_pl_tdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pl_hs_seen) begin
                if (pl_q.size() > 0) void'(pl_q.pop_front());
                pl_hs_seen = 1'b0;
            end
            phase = !phase;
            if (pl_q.size() > 0) begin
                bus.s_pl_tdata  = pl_q[0];
                bus.s_pl_tvalid = !pl_hold && (!pl_toggle || phase);
            end else begin
                bus.s_pl_tdata  = '0;
                bus.s_pl_tvalid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        vec_t        vecs [4];
        bit          acc;
        int          bubbles;
        bit          found;
        logic [31:0] s0;
        logic [63:0] b0;

        vecs[0] = '{4'd3,  16'h00A5, 64'h1122334455667788, 8'h00, 8'd0, 1'b0, 64'h0,   64'hD15C0003000000A5};
        vecs[1] = '{4'd5,  16'hBEEF, 64'h00000000DEAD0001, 8'h7F, 8'd3, 1'b1, 64'h0,   64'hD15C7F050000BEEF};
        vecs[2] = '{4'd15, 16'hFFFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd1, 1'b0, 64'h100, 64'hD15CFF0F0000FFFF};
        vecs[3] = '{4'd0,  16'h0001, 64'h0000000000000000, 8'h80, 8'd2, 1'b1, 64'h200, 64'hD15C800000000001};

        rst               = 1'b1;
        bus.cmp_valid     = 1'b0;
        bus.cmp_slot      = '0;
        bus.cmp_func_id   = '0;
        bus.cmp_token     = '0;
        bus.cmp_status    = '0;
        bus.cmp_len       = '0;
        bus.m_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_cmp_ready", 64'(bus.cmp_ready), 64'd1);
        check("post_reset_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("post_reset_free_en", 64'(free_en), 64'd0);
        step();

        // Table of single descriptors with tready held high
        for (int i = 0; i < 4; i++) begin
            pl_toggle = vecs[i].toggle;
            push_desc(vecs[i].slot, vecs[i].func, vecs[i].token, vecs[i].status, vecs[i].len,
                      vecs[i].exp_beat0, vecs[i].pl_base, 10, acc);
            check("vec_accept", 64'(acc), 64'd1);
            wait_drain(200, "vec");
            check("vec_cnt_packets", 64'(cnt_packets), 64'(i + 1));
            check("vec_free_pulses", 64'(free_pulses), 64'(i + 1));
        end
        pl_toggle = 1'b0;

        // Beat-0 latency and 4-cycle stall with stable beat
        bus.m_axis_tready = 1'b0;
        b0 = beat0(4'd9, 16'h1234, 8'h11);
        push_desc(4'd9, 16'h1234, 64'h000000000000CAFE, 8'h11, 8'd0, b0, 64'h0, 10, acc);
        check("stall_accept", 64'(acc), 64'd1);
        @(negedge clk);
        check("latency_n1_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        @(negedge clk);
        check("latency_n2_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        s0 = cnt_stalls;
        for (int i = 0; i < 4; i++) begin
            check("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
            check("stall_tdata", bus.m_axis_tdata, b0);
            check("stall_tlast", 64'(bus.m_axis_tlast), 64'd0);
            if (i < 3) @(negedge clk);
        end
        step();
        bus.m_axis_tready = 1'b1;
        wait_drain(100, "stall");
        check("stall_count_delta", 64'(cnt_stalls - s0), 64'd4);

        // FIFO fill while the engine is stuck on a header, then drain without bubbles
        bus.m_axis_tready = 1'b0;
        push_desc(4'd1, 16'h0A0A, 64'hA0, 8'h01, 8'd1, beat0(4'd1, 16'h0A0A, 8'h01), 64'h500, 10, acc);
        check("fill_accept_a", 64'(acc), 64'd1);
        push_desc(4'd2, 16'h0B0B, 64'hB0, 8'h02, 8'd0, beat0(4'd2, 16'h0B0B, 8'h02), 64'h600, 3, acc);
        check("fill_accept_1", 64'(acc), 64'd1);
        push_desc(4'd4, 16'h0C0C, 64'hC0, 8'h03, 8'd2, beat0(4'd4, 16'h0C0C, 8'h03), 64'h700, 3, acc);
        check("fill_accept_2", 64'(acc), 64'd1);
        push_desc(4'd6, 16'h0D0D, 64'hD0, 8'h04, 8'd1, beat0(4'd6, 16'h0D0D, 8'h04), 64'h800, 3, acc);
        check("fill_accept_3", 64'(acc), 64'd1);
        push_desc(4'd8, 16'h0E0E, 64'hE0, 8'h05, 8'd3, beat0(4'd8, 16'h0E0E, 8'h05), 64'h900, 3, acc);
        check("fill_accept_4", 64'(acc), 64'd1);
        push_desc(4'd10, 16'h0F0F, 64'hF0, 8'h06, 8'd0, beat0(4'd10, 16'h0F0F, 8'h06), 64'hA00, 3, acc);
        check("fill_refuse_5", 64'(acc), 64'd0);
        @(negedge clk);
        check("fill_cmp_ready", 64'(bus.cmp_ready), 64'd0);
        step();
        bus.m_axis_tready = 1'b1;
        bubbles = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            if (!bus.m_axis_tvalid) bubbles++;
        end
        check("fill_no_bubble", 64'(bubbles), 64'd0);
        wait_drain(100, "fill");
        check("fill_cnt_packets", 64'(cnt_packets), 64'(mdl_pkts));

        // Reset in the middle of a payload beat
        pl_hold = 1'b1;
        push_desc(4'd6, 16'h5555, 64'h77, 8'h22, 8'd2, beat0(4'd6, 16'h5555, 8'h22), 64'h300, 10, acc);
        check("rst_accept", 64'(acc), 64'd1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.s_pl_tready) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reached_payload", 64'(found), 64'd1);
        step();
        pl_hold = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("midrst");
        exp_q.delete();
        free_q.delete();
        pl_q.delete();
        pl_hs_seen  = 1'b0;
        mdl_pkts    = 0;
        mdl_stalls  = 0;
        free_pulses = 0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_free_en", 64'(free_en), 64'd0);
        end
        check("midrst_cmp_ready", 64'(bus.cmp_ready), 64'd1);
        step();
        push_desc(4'd7, 16'h4242, 64'h0123456789ABCDEF, 8'h33, 8'd2, 64'hD15C330700004242, 64'h400, 10, acc);
        check("fresh_accept", 64'(acc), 64'd1);
        wait_drain(100, "fresh");
        check("fresh_cnt_packets", 64'(cnt_packets), 64'd1);
        check("fresh_free_pulses", 64'(free_pulses), 64'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_cnt_packets", 64'(cnt_packets), 64'(mdl_pkts));
        check("final_cnt_stalls", 64'(cnt_stalls), 64'(mdl_stalls));
        check("final_tvalid_idle", 64'(bus.m_axis_tvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
